anim_sequencer: RTL
===================

Name: anim_sequencer

Overview:
Frame-level animation controller for the VGA demoscene top. It detects frame boundaries from the sync generator's vsync and steps NUM_CH independent triangle-wave offset channels that drive the sprite/box window comparators. It also sequences a fixed list of scenes, each lasting SCENE_FRAMES frames, and each scene sets the per-frame step size. Pause and single-frame-step controls come from ui_in, and the block runs entirely in the pixel clock domain.

Parameters:
NUM_CH, 3, number of offset channels
OFS_W, 10, offset width in bits (matches pix_x/pix_y width)
OFS_MAX, 200, upper turn-around value of every channel
SCENE_FRAMES, 240, frames per scene (must be >= 2)
NUM_SCENES, 4, scene count; scene index width is 2 bits, fixed

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
vsync  in  1  vsync level from the sync generator, synchronous to clk
pause  in  1  level; 1 = hold animation
step  in  1  level; a rising edge while paused requests one frame advance
offsets  out  NUM_CH*OFS_W  channel k occupies bits [k*OFS_W +: OFS_W]
dirs  out  NUM_CH  1 = channel counting up
scene  out  2  current scene index
frame_tick  out  1  one-cycle pulse per detected frame
scene_start  out  1  one-cycle pulse coincident with a scene change

Behaviour:
- Reset (async, rst_n=0):
  - offsets[k] = (k*OFS_MAX)/NUM_CH, truncated. With defaults: 0, 66, 133.
  - dirs = all 1; scene = 0; frame counter = 0.
  - frame_tick = 0; scene_start = 0; FSM = RUN; step request cleared; vsync_q = 0.
- Frame detect:
  - rise = vsync & ~vsync_q, where vsync_q is vsync registered once.
  - On the clk edge where rise=1, frame_tick is 1 for exactly one cycle, so it is visible the cycle after vsync is first seen high.
  - A vsync held high for many cycles produces exactly one tick.
- Advance: an "advance" happens on a rise edge when (FSM=RUN) or (FSM=PAUSE and step_req=1). All of the following update on that same edge as frame_tick.
- Step size by scene: 0 -> 1, 1 -> 2, 2 -> 4, 3 -> 0 (freeze: offsets and dirs hold, counter still runs).
- Channel update per advance (s = step, all arithmetic in OFS_W+1 bits, no wrap):
  - Up: if ofs+s >= OFS_MAX then ofs = OFS_MAX, dir = 0; else ofs = ofs+s.
  - Down: if ofs <= s then ofs = 0, dir = 1; else ofs = ofs-s.
  - With s=0, nothing changes, including at the endpoints.
- Scene counter per advance:
  - If frame counter = SCENE_FRAMES-1: counter = 0, scene = next scene, scene_start = 1 for one cycle.
  - Otherwise counter + 1.
  - Channel update uses the step of the scene in force before the change.
- FSM (two states, pause sampled every cycle):
  - RUN -> PAUSE when pause = 1.
  - PAUSE -> RUN when pause = 0; step_req is cleared on this transition.
  - step_req is set on a step rising edge (step & ~step_q) only while in PAUSE.
  - step_req is cleared when consumed by an advance. Multiple step edges before a tick give only one advance.
- Simultaneous events:
  - Rise and pause asserting in the same cycle: the advance still uses the current state (RUN), so the frame advances.
  - Step edge and consuming rise in the same cycle: that rise consumes step_req, and the new edge is dropped.
- Frame ticks while paused without step_req: frame_tick still pulses; offsets, scene and counter hold.
- All outputs are registered. No combinational path from inputs to outputs.

Optional Feature:
- Macro: ANIM_SHUFFLE_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'h01) steps once per scene change.
  - The next scene is lfsr_next[1:0]; if that equals the current scene, it is incremented mod 4.
  - scene_start behaves as normal.
- Undefined:
  - The next scene is (scene+1) mod NUM_SCENES, and no LFSR is present.

Test Plan:
- Reset, then pulse vsync high for 10 cycles once -> frame_tick is high for exactly 1 cycle, 1 cycle after the vsync rise; offsets go 0->1, 66->67, 133->134.
- 67 frames in scene 0 -> channel 2 reaches 200 at frame 67 and dir[2]=0; frame 68 -> 199.
- 240 frames -> scene_start pulses with frame_tick on frame 240, scene=1; frame 241 steps by 2.
- pause=1, 5 frames -> offsets and scene unchanged, frame_tick pulses 5 times; one step edge then 2 frames -> exactly one advance; pause=0 -> advances resume next frame.
- Scene 2 (step 4), channel at 198 going up -> next value 200 with dir=0; channel at 3 going down -> 0 with dir=1.
- Assert rst_n=0 mid-frame during scene 3 -> all outputs return to reset values immediately; with ANIM_SHUFFLE_EN, the first scene change yields a scene != 0, and the same sequence repeats after every reset.

Source files
------------

// File: rtl/anim_sequencer.sv
// Frame-level animation controller: vsync frame detect, triangle-wave offset channels, scene sequencing, pause/step.
// Optional scene shuffle via an 8-bit LFSR when ANIM_SHUFFLE_EN is defined; default is sequential scenes.
module anim_sequencer #(
    parameter int NUM_CH       = 3,
    parameter int OFS_W        = 10,
    parameter int OFS_MAX      = 200,
    parameter int SCENE_FRAMES = 240,
    parameter int NUM_SCENES   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      vsync,
    input  logic                      pause,
    input  logic                      step,
    output logic [NUM_CH*OFS_W-1:0]   offsets,
    output logic [NUM_CH-1:0]         dirs,
    output logic [1:0]                scene,
    output logic                      frame_tick,
    output logic                      scene_start
);

    localparam int                CNT_W    = (SCENE_FRAMES > 1) ? $clog2(SCENE_FRAMES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCENE_FRAMES - 1);
    localparam logic [OFS_W:0]    OFS_LIM  = (OFS_W+1)'(OFS_MAX);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             vsync_q;
    logic             step_q;
    logic             step_req_q, step_req_d;
    logic             rise, step_edge;
    logic             adv_en, advance, scene_wrap;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       scene_q, scene_d, scene_nxt;
    logic             frame_tick_q, scene_start_q;
    logic [OFS_W:0]   step_sz;

    assign rise      = vsync & ~vsync_q;
    assign step_edge = step & ~step_q;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (pause)  state_d = ST_PAUSE;
            ST_PAUSE: if (!pause) state_d = ST_RUN;
        endcase
    end

    // FSM: outputs. A consuming rise wins over a simultaneous step edge.
    always_comb begin
        adv_en     = 1'b0;
        step_req_d = step_req_q;
        case (state_q)
            ST_RUN: begin
                adv_en     = 1'b1;
                step_req_d = 1'b0;
            end
            ST_PAUSE: begin
                adv_en = step_req_q;
                if (!pause) begin
                    step_req_d = 1'b0;
                end else if (rise && step_req_q) begin
                    step_req_d = 1'b0;
                end else if (step_edge) begin
                    step_req_d = 1'b1;
                end
            end
        endcase
    end

    assign advance    = rise & adv_en;
    assign scene_wrap = advance && (cnt_q == CNT_LAST);

    always_comb begin
        step_sz = '0;
        case (scene_q)
            2'd0:    step_sz = (OFS_W+1)'(1);
            2'd1:    step_sz = (OFS_W+1)'(2);
            2'd2:    step_sz = (OFS_W+1)'(4);
            default: step_sz = '0;
        endcase
    end

`ifdef ANIM_SHUFFLE_EN
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_next;

    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_comb begin
        scene_nxt = (lfsr_next[1:0] == scene_q) ? scene_q + 2'd1 : lfsr_next[1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 8'h01;
        end else if (scene_wrap) begin
            lfsr_q <= lfsr_next;
        end
    end
`else
    always_comb begin
        scene_nxt = (scene_q == 2'(NUM_SCENES - 1)) ? 2'd0 : scene_q + 2'd1;
    end
`endif

    always_comb begin
        cnt_d   = cnt_q;
        scene_d = scene_q;
        if (scene_wrap) begin
            cnt_d   = '0;
            scene_d = scene_nxt;
        end else if (advance) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q       <= 1'b0;
            step_q        <= 1'b0;
            step_req_q    <= 1'b0;
            cnt_q         <= '0;
            scene_q       <= 2'd0;
            frame_tick_q  <= 1'b0;
            scene_start_q <= 1'b0;
        end else begin
            vsync_q       <= vsync;
            step_q        <= step;
            step_req_q    <= step_req_d;
            cnt_q         <= cnt_d;
            scene_q       <= scene_d;
            frame_tick_q  <= rise;
            scene_start_q <= scene_wrap;
        end
    end

    // Each channel bounces between 0 and OFS_MAX, clamping on overshoot; step 0 freezes it entirely.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam logic [OFS_W-1:0] OFS_INIT = OFS_W'((k * OFS_MAX) / NUM_CH);

        logic [OFS_W-1:0] ofs_q, ofs_d;
        logic             dir_q, dir_d;
        logic [OFS_W:0]   ofs_ext, sum;

        assign ofs_ext = {1'b0, ofs_q};
        assign sum     = ofs_ext + step_sz;

        always_comb begin
            ofs_d = ofs_q;
            dir_d = dir_q;
            if (advance && (step_sz != '0)) begin
                if (dir_q) begin
                    if (sum >= OFS_LIM) begin
                        ofs_d = OFS_LIM[OFS_W-1:0];
                        dir_d = 1'b0;
                    end else begin
                        ofs_d = sum[OFS_W-1:0];
                    end
                end else begin
                    if (ofs_ext <= step_sz) begin
                        ofs_d = '0;
                        dir_d = 1'b1;
                    end else begin
                        ofs_d = ofs_q - step_sz[OFS_W-1:0];
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ofs_q <= OFS_INIT;
                dir_q <= 1'b1;
            end else begin
                ofs_q <= ofs_d;
                dir_q <= dir_d;
            end
        end

        assign offsets[k*OFS_W +: OFS_W] = ofs_q;
        assign dirs[k]                   = dir_q;
    end

    assign scene       = scene_q;
    assign frame_tick  = frame_tick_q;
    assign scene_start = scene_start_q;

endmodule
